// File: rtl/pool_pkg.sv
// Shared constants for the 2x2 pooling stream: mode encoding and accumulator sizing.
package pool_pkg;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  // Sum of four DATA_W-bit samples needs two guard bits.
  function automatic int acc_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/pool2d_stream_if.sv
// Pixel-in / pooled-pixel-out stream bundle with mode select; master drives pixels, slave is the pooler.
interface pool2d_stream_if #(
  parameter int DATA_W = 16
);

  logic                     mode;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/pool_combine.sv
// Two-operand combine, purely combinational: sign-extended sum (avg) or signed maximum (max).
// Result is one bit wider than the operands so the sum never overflows.
module pool_combine
  import pool_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                mode,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W:0]   y
);

  always_comb begin
    y = '0;
    if (mode == POOL_MAX) begin
      y = (a > b) ? {a[W-1], a} : {b[W-1], b};
    end else begin
      y = {a[W-1], a} + {b[W-1], b};
    end
  end

endmodule

// File: rtl/pool2d_stream.sv
// 2x2 stride-2 avg/max pooling over a raster pixel stream; output registered, 1 cycle after the completing beat.
// Backpressure: in_ready = !out_valid || out_ready, so a stalled output stalls the input with no loss.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input logic            clk,
  input logic            rst_n,
  pool2d_stream_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int LW = (CW > 1) ? CW - 1 : 1;
  localparam int HW = DATA_W + 1;
  localparam int VW = acc_w(DATA_W);

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [LW-1:0]            col_half;
  logic signed [DATA_W-1:0] pair;
  logic                     mode_q;
  logic signed [HW-1:0]     lbuf [WIDTH/2];
  logic signed [HW-1:0]     lb_rd;
  logic signed [HW-1:0]     h_res;
  logic signed [VW-1:0]     v_res;
  logic signed [DATA_W-1:0] pooled;
  logic signed [DATA_W-1:0] out_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     in_ready;
  logic                     accept;
  logic                     col_end;
  logic                     row_end;
  logic                     frame_start;

  assign in_ready    = !valid_q || bus.out_ready;
  assign accept      = bus.in_valid && in_ready;
  assign col_end     = (col == CW'(WIDTH - 1));
  assign row_end     = (row == RW'(HEIGHT - 1));
  assign frame_start = (col == '0) && (row == '0);
  assign col_half    = LW'(col >> 1);
  assign lb_rd       = lbuf[col_half];

  pool_combine #(.W(DATA_W)) u_horiz (
    .mode (mode_q),
    .a    (pair),
    .b    (bus.in_data),
    .y    (h_res)
  );

  pool_combine #(.W(HW)) u_vert (
    .mode (mode_q),
    .a    (lb_rd),
    .b    (h_res),
    .y    (v_res)
  );

  // Arithmetic shift floors toward -inf, matching the required average rounding.
  assign pooled = (mode_q == POOL_MAX) ? DATA_W'(v_res) : DATA_W'(v_res >>> 2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      pair    <= '0;
      mode_q  <= POOL_AVG;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (frame_start) mode_q <= bus.mode;
        if (!col[0]) pair <= bus.in_data;
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // A new result may land in the same cycle the old one leaves: no bubble.
      if (accept && row[0] && col[0]) begin
        out_q   <= pooled;
        valid_q <= 1'b1;
        last_q  <= row_end && col_end;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Line buffer has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) lbuf[col_half] <= h_res;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed and random-frame checks of pool2d_stream on a 4x2 and a 28x28 instance.
module tb_pool2d_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  pool2d_stream_if #(.DATA_W(16)) s_if ();
  pool2d_stream_if #(.DATA_W(16)) l_if ();

  pool2d_stream #(.DATA_W(16), .WIDTH(4), .HEIGHT(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  pool2d_stream #(.DATA_W(16), .WIDTH(28), .HEIGHT(28)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (l_if)
  );

  int sq_d[$];
  bit sq_l[$];
  int lq_d[$];
  bit lq_l[$];
  int l_stall = 0;
  int pix  [784];
  int gold [196];

  always @(negedge clk) begin
    if (rst_n && s_if.out_valid && s_if.out_ready) begin
      sq_d.push_back(int'(s_if.out_data));
      sq_l.push_back(s_if.out_last);
    end
    if (rst_n && l_if.out_valid && l_if.out_ready) begin
      lq_d.push_back(int'(l_if.out_data));
      lq_l.push_back(l_if.out_last);
    end
    if (rst_n && l_if.out_ready && !l_if.in_ready) l_stall++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_s(input int d, input bit m);
    int n;
    n = 0;
    s_if.in_data  = 16'(d);
    s_if.mode     = m;
    s_if.in_valid = 1'b1;
    @(negedge clk);
    while (!s_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("s_in_timeout", n, 0);
    @(posedge clk);
    #1 s_if.in_valid = 1'b0;
  endtask

  task automatic drive_l(input int d, input bit m);
    int n;
    n = 0;
    l_if.in_data  = 16'(d);
    l_if.mode     = m;
    l_if.in_valid = 1'b1;
    @(negedge clk);
    while (!l_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("l_in_timeout", n, 0);
    @(posedge clk);
    #1 l_if.in_valid = 1'b0;
  endtask

  task automatic frame_s(input string tag, input int px[8], input bit md[8],
                         input int e0, input int e1);
    sq_d.delete();
    sq_l.delete();
    for (int i = 0; i < 8; i++) begin
      drive_s(px[i], md[i]);
      if (i == 4) check_eq({tag, "_pre_vld"}, s_if.out_valid, 0);
      if (i == 5) begin
        check_eq({tag, "_lat_vld"}, s_if.out_valid, 1);
        check_eq({tag, "_lat_dat"}, s_if.out_data, e0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, sq_d.size(), 2);
    if (sq_d.size() == 2) begin
      check_eq({tag, "_d0"}, sq_d[0], e0);
      check_eq({tag, "_d1"}, sq_d[1], e1);
      check_eq({tag, "_last0"}, sq_l[0], 0);
      check_eq({tag, "_last1"}, sq_l[1], 1);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 784; i++) begin
      case ($urandom_range(0, 15))
        0:       pix[i] = 32767;
        1:       pix[i] = -32768;
        default: pix[i] = int'($urandom_range(0, 65535)) - 32768;
      endcase
    end
  endtask

  task automatic make_gold(input bit m);
    int a, b, c, d, mx;
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < 14; k++) begin
        a = pix[(2*r)*28 + 2*k];
        b = pix[(2*r)*28 + 2*k + 1];
        c = pix[(2*r+1)*28 + 2*k];
        d = pix[(2*r+1)*28 + 2*k + 1];
        if (m) begin
          mx = a;
          if (b > mx) mx = b;
          if (c > mx) mx = c;
          if (d > mx) mx = d;
          gold[r*14 + k] = mx;
        end else begin
          gold[r*14 + k] = (a + b + c + d) >>> 2;
        end
      end
    end
  endtask

  task automatic run_l(input bit m);
    for (int i = 0; i < 784; i++) drive_l(pix[i], m);
  endtask

  task automatic check_l(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, lq_d.size(), 196);
    for (int i = 0; i < lq_d.size() && i < 196; i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), lq_d[i], gold[i]);
      check_eq($sformatf("%s_last%0d", tag, i), lq_l[i], (i == 195) ? 1 : 0);
    end
  endtask

  initial begin
    int px[8];
    bit md[8];
    bit m0[8];
    bit m1[8];
    int held;
    int n;

    rst_n = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.mode = 1'b0; s_if.out_ready = 1'b1;
    l_if.in_valid = 1'b0; l_if.in_data = '0; l_if.mode = 1'b0; l_if.out_ready = 1'b1;
    m0 = '{default: 1'b0};
    m1 = '{default: 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check_eq("s_rst_vld", s_if.out_valid, 0);
    check_eq("s_rst_dat", s_if.out_data, 0);
    check_eq("s_rst_last", s_if.out_last, 0);
    check_eq("s_rst_rdy", s_if.in_ready, 1);
    check_eq("l_rst_vld", l_if.out_valid, 0);
    check_eq("l_rst_rdy", l_if.in_ready, 1);

    px = '{1, 2, 3, 4, 5, 6, 7, 8};
    frame_s("avg_basic", px, m0, 3, 5);
    frame_s("max_basic", px, m1, 6, 8);

    px = '{-4, -1, 0, 0, -3, -2, 0, 0};
    frame_s("max_neg", px, m1, -1, 0);
    frame_s("avg_neg", px, m0, -3, 0);

    px = '{default: 32767};
    frame_s("avg_pos_ext", px, m0, 32767, 32767);
    px = '{default: -32768};
    frame_s("avg_neg_ext", px, m0, -32768, -32768);

    px = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, 32767};
    frame_s("max_mix_ext", px, m1, 32767, 32767);
    frame_s("avg_mix_ext", px, m0, -16385, -16385);

    px = '{1, 2, 3, 4, 5, 6, 7, 8};
    md = '{0, 1, 1, 1, 1, 1, 1, 1};
    frame_s("mode_hold", px, md, 3, 5);
    md = '{1, 0, 0, 0, 0, 0, 0, 0};
    frame_s("mode_next", px, md, 6, 8);

    // Large frame with the first output held off for five cycles.
    lq_d.delete(); lq_l.delete();
    fill_rand();
    make_gold(1'b0);
    l_if.out_ready = 1'b0;
    fork
      run_l(1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (!l_if.out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        check_eq("bp_first_seen", (n < 200) ? 1 : 0, 1);
        held = int'(l_if.out_data);
        check_eq("bp_first_dat", held, gold[0]);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_eq($sformatf("bp_vld%0d", k), l_if.out_valid, 1);
          check_eq($sformatf("bp_dat%0d", k), l_if.out_data, held);
          check_eq($sformatf("bp_rdy%0d", k), l_if.in_ready, 0);
        end
        @(posedge clk);
        #1 l_if.out_ready = 1'b1;
      end
    join
    check_l("bp");

    lq_d.delete(); lq_l.delete();
    l_stall = 0;
    fill_rand();
    make_gold(1'b1);
    run_l(1'b1);
    check_l("max_full");
    check_eq("full_rate_stalls", l_stall, 0);

    // Abandon a frame part way through row 1.
    fill_rand();
    for (int i = 0; i < 40; i++) drive_l(pix[i], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("mid_rst_vld", l_if.out_valid, 0);
    check_eq("mid_rst_last", l_if.out_last, 0);
    check_eq("mid_rst_dat", l_if.out_data, 0);
    check_eq("mid_rst_rdy", l_if.in_ready, 1);
    lq_d.delete(); lq_l.delete();
    fill_rand();
    make_gold(1'b0);
    run_l(1'b0);
    check_l("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
